// File: rtl/dmem_arbiter.sv
// Arbitrates the data-memory port between the CPU MEM stage and one external requester; the mux is combinational, ext read data returns one cycle after grant.
// The CPU has fixed priority; DMEM_ARB_PERF_EN adds contention/forced-grant counters.
module dmem_arbiter #(
    parameter int MAX_WAIT = 8,
    parameter int WAIT_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [13:0]       cpu_addr,
    input  logic [31:0]       cpu_wrdata,
    input  logic              cpu_memwrite,
    input  logic              cpu_memread,
    input  logic [2:0]        cpu_sign_mask,
    output logic              cpu_stall,
    input  logic              ext_req,
    input  logic              ext_we,
    input  logic [13:0]       ext_addr,
    input  logic [31:0]       ext_wdata,
    input  logic [2:0]        ext_sign_mask,
    output logic              ext_gnt,
    output logic              ext_rvalid,
    output logic [31:0]       ext_rdata,
    output logic [13:0]       mem_addr,
    output logic [31:0]       mem_wrdata,
    output logic              mem_memwrite,
    output logic              mem_memread,
    output logic [2:0]        mem_sign_mask,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       cpu_rdata
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [31:0]       perf_contend,
    output logic [15:0]       perf_forced
`endif
);

    typedef enum logic {CPU_OWN, FORCE} state_t;

    // The forced grant lands on the MAX_WAIT-th cycle the ext request is held.
    localparam logic [WAIT_W-1:0] FORCE_AT = WAIT_W'(MAX_WAIT - 1);

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d, wait_inc;
    logic              rvalid_q;
    logic [31:0]       rdata_q;
    logic              cpu_act, sel_cpu, sel_ext;

    always_comb begin
        cpu_act   = cpu_memread | cpu_memwrite;
        state_d   = state_q;
        wait_d    = wait_q;
        sel_cpu   = 1'b0;
        sel_ext   = 1'b0;
        cpu_stall = 1'b0;
        wait_inc  = (wait_q == '1) ? wait_q : wait_q + WAIT_W'(1);
        case (state_q)
            CPU_OWN: begin
                if (cpu_act) begin
                    sel_cpu = 1'b1;
                    if (ext_req) begin
                        wait_d = wait_inc;
                        if (wait_inc >= FORCE_AT) begin
                            state_d = FORCE;
                        end
                    end else begin
                        wait_d = '0;
                    end
                end else begin
                    sel_ext = ext_req;
                    wait_d  = '0;
                end
            end
            FORCE: begin
                // A dropped ext_req here is a protocol error: nothing is issued.
                cpu_stall = 1'b1;
                sel_ext   = ext_req;
                wait_d    = '0;
                state_d   = CPU_OWN;
            end
            default: state_d = CPU_OWN;
        endcase
    end

    always_comb begin
        mem_addr      = '0;
        mem_wrdata    = '0;
        mem_memwrite  = 1'b0;
        mem_memread   = 1'b0;
        mem_sign_mask = '0;
        if (sel_cpu) begin
            mem_addr      = cpu_addr;
            mem_wrdata    = cpu_wrdata;
            mem_memwrite  = cpu_memwrite;
            mem_memread   = cpu_memread;
            mem_sign_mask = cpu_sign_mask;
        end else if (sel_ext) begin
            mem_addr      = ext_addr;
            mem_wrdata    = ext_wdata;
            mem_memwrite  = ext_we;
            mem_memread   = ~ext_we;
            mem_sign_mask = ext_sign_mask;
        end
    end

    assign ext_gnt    = sel_ext;
    assign ext_rvalid = rvalid_q;
    assign ext_rdata  = rvalid_q ? mem_rdata : rdata_q;
    assign cpu_rdata  = mem_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= CPU_OWN;
            wait_q   <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            rvalid_q <= sel_ext & ~ext_we;
            if (rvalid_q) begin
                rdata_q <= mem_rdata;
            end
        end
    end

`ifdef DMEM_ARB_PERF_EN
    logic [31:0] contend_q;
    logic [15:0] forced_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            contend_q <= '0;
            forced_q  <= '0;
        end else begin
            if (cpu_act && ext_req) begin
                contend_q <= contend_q + 32'd1;
            end
            if (state_q == CPU_OWN && state_d == FORCE) begin
                forced_q <= forced_q + 16'd1;
            end
        end
    end

    assign perf_contend = contend_q;
    assign perf_forced  = forced_q;
`endif

endmodule
